// File: rtl/vga_dual_window_out.sv
// vga_dual_window_out: VGA timing and two-window RGB565 compositor with look-ahead pixel requests; define VGA_TEST_PATTERN_EN to add a test_en colour-bar override
module vga_dual_window_out #(
  parameter int HD = 640,
  parameter int HF = 16,
  parameter int HS = 96,
  parameter int HB = 48,
  parameter int VD = 480,
  parameter int VF = 10,
  parameter int VS = 2,
  parameter int VB = 33,
  parameter int HS_POL = 0,
  parameter int VS_POL = 0,
  parameter int LAT = 2,
  parameter int A_X0 = 0,
  parameter int A_Y0 = 120,
  parameter int A_W = 320,
  parameter int A_H = 240,
  parameter int B_X0 = 320,
  parameter int B_Y0 = 120,
  parameter int B_W = 320,
  parameter int B_H = 240,
  parameter logic [15:0] BG_COLOR = 16'h0000
) (
  input  logic        vga_pclk,
  input  logic        vga_rst,
`ifdef VGA_TEST_PATTERN_EN
  input  logic        test_en,
`endif
  input  logic [15:0] rgb_a,
  input  logic [15:0] rgb_b,
  output logic        req_a,
  output logic        req_b,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_de,
  output logic [4:0]  vga_red,
  output logic [5:0]  vga_green,
  output logic [4:0]  vga_blue,
  output logic        frame_start,
  output logic [11:0] vga_h_cnt,
  output logic [10:0] vga_v_cnt
);
  localparam int HT = HD + HF + HS + HB;
  localparam int VT = VD + VF + VS + VB;
  localparam logic HP = HS_POL != 0;
  localparam logic VP = VS_POL != 0;
`ifdef VGA_TEST_PATTERN_EN
  localparam int DW = 10;
  localparam logic [15:0] BARS [8] = '{16'hFFFF, 16'hFFE0, 16'h07FF, 16'h07E0,
                                       16'hF81F, 16'hF800, 16'h001F, 16'h0000};
`else
  localparam int DW = 6;
`endif
  logic [11:0]   r_h;
  logic [10:0]   r_v;
  logic [31:0]   w_h, w_v;
  logic          w_act, w_ina, w_inb, w_ra, w_rb, w_hs, w_vs;
  logic [DW-1:0] w_d;
  logic [DW-1:0] r_dl [0:LAT];
  logic [15:0]   w_rgb;
  assign w_h = 32'(r_h);
  assign w_v = 32'(r_v);
  assign w_act = w_h < HD && w_v < VD;
  assign w_ina = w_act && w_h >= A_X0 && w_h < A_X0 + A_W && w_v >= A_Y0 && w_v < A_Y0 + A_H;
  assign w_inb = w_act && w_h >= B_X0 && w_h < B_X0 + B_W && w_v >= B_Y0 && w_v < B_Y0 + B_H;
  assign w_hs = w_h >= HD + HF && w_h < HD + HF + HS;
  assign w_vs = w_v >= VD + VF && w_v < VD + VF + VS;
  assign vga_h_cnt = w_act ? r_h : '0;
  assign vga_v_cnt = w_act ? r_v : '0;
  // delay-line word: {fs, selB, selA, de, vs, hs}, plus {bar, tp} when bars are built in
  assign w_d[5:0] = {w_h == 0 && w_v == 0, w_rb, w_ra, w_act, w_vs, w_hs};
`ifdef VGA_TEST_PATTERN_EN
  assign w_ra = w_ina && !test_en;
  assign w_rb = w_inb && !w_ina && !test_en;
  assign w_d[9:6] = {3'(w_h / (HD / 8)), test_en};
  assign w_rgb = !r_dl[LAT][2] ? 16'h0000 : r_dl[LAT][6] ? BARS[r_dl[LAT][9:7]] :
                 r_dl[LAT][3] ? rgb_a : r_dl[LAT][4] ? rgb_b : BG_COLOR;
`else
  assign w_ra = w_ina;
  assign w_rb = w_inb && !w_ina;
  assign w_rgb = !r_dl[LAT][2] ? 16'h0000 : r_dl[LAT][3] ? rgb_a : r_dl[LAT][4] ? rgb_b : BG_COLOR;
`endif
  // stage-0 raster counters
  always_ff @(posedge vga_pclk or negedge vga_rst)
    if (!vga_rst) begin
      r_h <= '0;
      r_v <= '0;
    end else begin
      r_h <= w_h == HT - 1 ? '0 : r_h + 12'd1;
      if (w_h == HT - 1) r_v <= w_v == VT - 1 ? '0 : r_v + 11'd1;
    end
  // registered requests and sideband delay line matching the source latency
  always_ff @(posedge vga_pclk or negedge vga_rst)
    if (!vga_rst) begin
      req_a <= 1'b0;
      req_b <= 1'b0;
      for (int i = 0; i <= LAT; i++) r_dl[i] <= '0;
    end else begin
      req_a <= w_ra;
      req_b <= w_rb;
      r_dl[0] <= w_d;
      for (int i = 1; i <= LAT; i++) r_dl[i] <= r_dl[i-1];
    end
  // output register: sync polarity, enable, frame pulse and selected pixel
  always_ff @(posedge vga_pclk or negedge vga_rst)
    if (!vga_rst) begin
      vga_hsync <= !HP;
      vga_vsync <= !VP;
      vga_de <= 1'b0;
      frame_start <= 1'b0;
      {vga_red, vga_green, vga_blue} <= '0;
    end else begin
      vga_hsync <= r_dl[LAT][0] ? HP : !HP;
      vga_vsync <= r_dl[LAT][1] ? VP : !VP;
      vga_de <= r_dl[LAT][2];
      frame_start <= r_dl[LAT][5];
      {vga_red, vga_green, vga_blue} <= w_rgb;
    end
endmodule

// File: tb/tb_vga_dual_window_out.sv
// tb_vga_dual_window_out: directed bench for vga_dual_window_out on reduced timing with three window/latency configurations
module tb_vga_dual_window_out;
  localparam int HT = 48;
  localparam int VT = 18;
  localparam int FR = HT * VT;
  localparam int LATS [3] = '{2, 5, 3};
  localparam int POLS [3] = '{0, 1, 0};

  typedef struct {
    int d; int x; int y;
    logic [15:0] rgb; logic de; logic hs; logic vs;
  } vec_t;

  logic clk = 1'b0, rst = 1'b0, te = 1'b0;
  logic [15:0] ra [3], rb [3], rgb [3];
  logic qa [3], qb [3], hs [3], vs [3], de [3], fs [3];
  logic [4:0] r5 [3], b5 [3];
  logic [5:0] g6 [3];
  logic [11:0] hc [3];
  logic [10:0] vc [3];
  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  vga_dual_window_out #(.HD(32), .HF(4), .HS(8), .HB(4), .VD(12), .VF(2), .VS(2), .VB(2),
    .HS_POL(0), .VS_POL(0), .LAT(2), .A_X0(0), .A_Y0(3), .A_W(16), .A_H(6),
    .B_X0(16), .B_Y0(3), .B_W(16), .B_H(6), .BG_COLOR(16'h1234)) u0 (
    .vga_pclk(clk), .vga_rst(rst),
`ifdef VGA_TEST_PATTERN_EN
    .test_en(te),
`endif
    .rgb_a(ra[0]), .rgb_b(rb[0]), .req_a(qa[0]), .req_b(qb[0]), .vga_hsync(hs[0]),
    .vga_vsync(vs[0]), .vga_de(de[0]), .vga_red(r5[0]), .vga_green(g6[0]), .vga_blue(b5[0]),
    .frame_start(fs[0]), .vga_h_cnt(hc[0]), .vga_v_cnt(vc[0]));

  vga_dual_window_out #(.HD(32), .HF(4), .HS(8), .HB(4), .VD(12), .VF(2), .VS(2), .VB(2),
    .HS_POL(1), .VS_POL(1), .LAT(5), .A_X0(0), .A_Y0(0), .A_W(16), .A_H(6),
    .B_X0(10), .B_Y0(3), .B_W(30), .B_H(6), .BG_COLOR(16'h0F0F)) u1 (
    .vga_pclk(clk), .vga_rst(rst),
`ifdef VGA_TEST_PATTERN_EN
    .test_en(1'b0),
`endif
    .rgb_a(ra[1]), .rgb_b(rb[1]), .req_a(qa[1]), .req_b(qb[1]), .vga_hsync(hs[1]),
    .vga_vsync(vs[1]), .vga_de(de[1]), .vga_red(r5[1]), .vga_green(g6[1]), .vga_blue(b5[1]),
    .frame_start(fs[1]), .vga_h_cnt(hc[1]), .vga_v_cnt(vc[1]));

  vga_dual_window_out #(.HD(32), .HF(4), .HS(8), .HB(4), .VD(12), .VF(2), .VS(2), .VB(2),
    .HS_POL(0), .VS_POL(0), .LAT(3), .A_X0(0), .A_Y0(3), .A_W(0), .A_H(6),
    .B_X0(16), .B_Y0(3), .B_W(16), .B_H(0), .BG_COLOR(16'h00FF)) u2 (
    .vga_pclk(clk), .vga_rst(rst),
`ifdef VGA_TEST_PATTERN_EN
    .test_en(1'b0),
`endif
    .rgb_a(ra[2]), .rgb_b(rb[2]), .req_a(qa[2]), .req_b(qb[2]), .vga_hsync(hs[2]),
    .vga_vsync(vs[2]), .vga_de(de[2]), .vga_red(r5[2]), .vga_green(g6[2]), .vga_blue(b5[2]),
    .frame_start(fs[2]), .vga_h_cnt(hc[2]), .vga_v_cnt(vc[2]));

  for (genvar g = 0; g < 3; g++) begin : g_rgb
    assign rgb[g] = {r5[g], g6[g], b5[g]};
  end

  // source model: each pop returns {tag, running count} exactly LAT cycles after the request
  logic [15:0] sa [3][8], sb [3][8];
  logic [11:0] ca [3], cb [3];
  always @(posedge clk)
    for (int i = 0; i < 3; i++)
      if (!rst) begin
        ca[i] <= '0;
        cb[i] <= '0;
      end else begin
        if (qa[i]) ca[i] <= ca[i] + 12'd1;
        if (qb[i]) cb[i] <= cb[i] + 12'd1;
        sa[i][0] <= qa[i] ? {4'hA, ca[i]} : 16'hBAD0;
        sb[i][0] <= qb[i] ? {4'hB, cb[i]} : 16'hBAD0;
        for (int k = 1; k < 8; k++) begin
          sa[i][k] <= sa[i][k-1];
          sb[i][k] <= sb[i][k-1];
        end
      end
  always_comb
    for (int i = 0; i < 3; i++) begin
      ra[i] = sa[i][LATS[i]-1];
      rb[i] = sb[i][LATS[i]-1];
    end

  logic [15:0] frgb [3][VT][HT];
  logic fde [3][VT][HT], fhs [3][VT][HT], fvs [3][VT][HT];
  int cqa [3], cqb [3], chs [3], cvs [3], cde [3], fsw [3], fsf [3];
  logic e_qa [16], e_de [16], e_fs [16];
  logic [11:0] hcn [FR];
  logic [10:0] vcn [FR];
  vec_t tbl [$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // n counts posedges since reset release; stage-0 index n shows on outputs at n+LAT+2
  task automatic run(input int cycles);
    int k;
    for (int i = 0; i < 3; i++) begin
      cqa[i] = 0; cqb[i] = 0; chs[i] = 0; cvs[i] = 0; cde[i] = 0; fsw[i] = 0; fsf[i] = -1;
    end
    for (int n = 1; n <= cycles; n++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        k = n - LATS[i] - 2;
        if (k >= 0 && k < FR) begin
          frgb[i][k/HT][k%HT] = rgb[i];
          fde[i][k/HT][k%HT] = de[i];
          fhs[i][k/HT][k%HT] = hs[i];
          fvs[i][k/HT][k%HT] = vs[i];
        end
        if (n >= FR && n < 2 * FR) begin
          if (qa[i]) cqa[i]++;
          if (qb[i]) cqb[i]++;
          if (hs[i] == (POLS[i] != 0)) chs[i]++;
          if (vs[i] == (POLS[i] != 0)) cvs[i]++;
          if (de[i]) cde[i]++;
        end
        if (n < FR && fs[i]) begin
          fsw[i]++;
          if (fsf[i] < 0) fsf[i] = n;
        end
      end
      if (n < 16) begin
        e_qa[n] = qa[1]; e_de[n] = de[1]; e_fs[n] = fs[1];
      end
      if (n < FR) begin
        hcn[n] = hc[0]; vcn[n] = vc[0];
      end
    end
  endtask

  task automatic chk_reset(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s_req_a%0d", tag, i), qa[i], 0);
      chk($sformatf("%s_req_b%0d", tag, i), qb[i], 0);
      chk($sformatf("%s_de%0d", tag, i), de[i], 0);
      chk($sformatf("%s_rgb%0d", tag, i), rgb[i], 0);
      chk($sformatf("%s_fs%0d", tag, i), fs[i], 0);
      chk($sformatf("%s_hs%0d", tag, i), hs[i], POLS[i] == 0);
      chk($sformatf("%s_vs%0d", tag, i), vs[i], POLS[i] == 0);
      chk($sformatf("%s_vcnt%0d", tag, i), vc[i], 0);
    end
  endtask

  initial begin
    int t;
    tbl.push_back('{0, 0, 0, 16'h1234, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{0, 0, 3, 16'hA000, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{0, 15, 3, 16'hA00F, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{0, 16, 3, 16'hB000, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{0, 31, 3, 16'hB00F, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{0, 0, 4, 16'hA010, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{0, 15, 8, 16'hA05F, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{0, 17, 8, 16'hB051, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{0, 5, 2, 16'h1234, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{0, 5, 9, 16'h1234, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{0, 31, 11, 16'h1234, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{0, 32, 3, 16'h0000, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{0, 35, 0, 16'h0000, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{0, 36, 0, 16'h0000, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{0, 43, 0, 16'h0000, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{0, 44, 0, 16'h0000, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{0, 0, 13, 16'h0000, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{0, 0, 14, 16'h0000, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{0, 40, 15, 16'h0000, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{0, 0, 16, 16'h0000, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1, 0, 0, 16'hA000, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1, 15, 0, 16'hA00F, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1, 16, 0, 16'h0F0F, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1, 10, 3, 16'hA03A, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1, 16, 3, 16'hB000, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1, 31, 3, 16'hB00F, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1, 10, 6, 16'hB030, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1, 31, 8, 16'hB071, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1, 12, 9, 16'h0F0F, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1, 36, 0, 16'h0000, 1'b0, 1'b1, 1'b0});
    tbl.push_back('{1, 0, 14, 16'h0000, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{2, 0, 3, 16'h00FF, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{2, 20, 5, 16'h00FF, 1'b1, 1'b1, 1'b1});
    tbl.push_back('{2, 33, 5, 16'h0000, 1'b0, 1'b1, 1'b1});

    repeat (3) @(negedge clk);
    #1;
    chk_reset("por");
    rst = 1'b1;
    run(2 * FR + 20);

    foreach (tbl[j]) begin
      chk($sformatf("vec%0d_rgb", j), frgb[tbl[j].d][tbl[j].y][tbl[j].x], tbl[j].rgb);
      chk($sformatf("vec%0d_de", j), fde[tbl[j].d][tbl[j].y][tbl[j].x], tbl[j].de);
      chk($sformatf("vec%0d_hs", j), fhs[tbl[j].d][tbl[j].y][tbl[j].x], tbl[j].hs);
      chk($sformatf("vec%0d_vs", j), fvs[tbl[j].d][tbl[j].y][tbl[j].x], tbl[j].vs);
    end

    chk("cnt_req_a0", cqa[0], 96);
    chk("cnt_req_b0", cqb[0], 96);
    chk("cnt_hs0", chs[0], 144);
    chk("cnt_vs0", cvs[0], 96);
    chk("cnt_de0", cde[0], 384);
    chk("cnt_req_a1", cqa[1], 96);
    chk("cnt_req_b1", cqb[1], 114);
    chk("cnt_hs1", chs[1], 144);
    chk("cnt_vs1", cvs[1], 96);
    chk("cnt_req_a2", cqa[2], 0);
    chk("cnt_req_b2", cqb[2], 0);
    chk("cnt_de2", cde[2], 384);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("fs_count%0d", i), fsw[i], 1);
      chk($sformatf("fs_first%0d", i), fsf[i], LATS[i] + 2);
    end

    chk("lat5_req_first", e_qa[1], 1);
    chk("lat5_de_n6", e_de[6], 0);
    chk("lat5_de_n7", e_de[7], 1);
    chk("lat5_fs_n7", e_fs[7], 1);
    chk("lat5_fs_n8", e_fs[8], 0);

    chk("hcnt_n5", hcn[5], 5);
    chk("vcnt_n5", vcn[5], 0);
    chk("hcnt_n51", hcn[51], 3);
    chk("vcnt_n51", vcn[51], 1);
    chk("hcnt_n100", hcn[100], 4);
    chk("vcnt_n100", vcn[100], 2);
    chk("hcnt_blank", hcn[40], 0);
    chk("vcnt_blank", vcn[578], 0);

    t = 0;
    while (!(hc[0] == 20 && vc[0] == 5) && t < 2 * FR) begin
      @(negedge clk);
      t++;
    end
    chk("midline_reached", t < 2 * FR, 1);
    chk("midline_de_before", de[0], 1);
    #2 rst = 1'b0;
    #1 chk_reset("mid");
    chk("mid_hcnt0", hc[0], 0);
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    run(FR + 20);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("restart_fs_count%0d", i), fsw[i], 1);
      chk($sformatf("restart_fs_first%0d", i), fsf[i], LATS[i] + 2);
    end
    chk("restart_req_first", e_qa[1], 1);
    chk("restart_a0_pixel", frgb[1][0][0], 16'hA000);
    chk("restart_b0_pixel", frgb[0][3][16], 16'hB000);

`ifdef VGA_TEST_PATTERN_EN
    te = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    run(2 * FR + 20);
    chk("bar_x0", frgb[0][4][0], 16'hFFFF);
    chk("bar_x4", frgb[0][4][4], 16'hFFE0);
    chk("bar_x8", frgb[0][4][8], 16'h07FF);
    chk("bar_x28", frgb[0][4][28], 16'h0000);
    chk("bar_de", fde[0][4][28], 1);
    chk("bar_blank", frgb[0][4][33], 16'h0000);
    chk("bar_req_a", cqa[0], 0);
    chk("bar_req_b", cqb[0], 0);
    chk("bar_other_req_a", cqa[1], 96);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
